// File: rtl/id_ex_stage_if.sv
// Decode/hazard-unit side of the ID/EX register: D-stage operands and controls in,
// ALU operands and EX control bundle out.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic            StallE;
  logic            FlushE;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ImmExtD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;
  logic [2:0]      ALUCtrlD;
  logic            ALUSrcD;
  logic            RegWriteD;
  logic            MemWriteD;
  logic            JumpD;
  logic            BranchD;
  logic [1:0]      ResultSrcD;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] ResultW;

  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [2:0]      ALUCtrlE;
  logic [XLEN-1:0] WriteDataE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            ValidE;
  logic [1:0]      ResultSrcE;

  modport master (
    output StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
           ALUCtrlD, ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD, ResultSrcD,
           ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  SrcAE, SrcBE, ALUCtrlE, WriteDataE, PCTargetE, PCPlus4E, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, JumpE, BranchE, ValidE, ResultSrcE
  );

  modport slave (
    input  StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
           ALUCtrlD, ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD, ResultSrcD,
           ForwardAE, ForwardBE, ALUResultM, ResultW,
    output SrcAE, SrcBE, ALUCtrlE, WriteDataE, PCTargetE, PCPlus4E, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, JumpE, BranchE, ValidE, ResultSrcE
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, forwarding muxes for the ALU operands
// and the branch/jump target adder.
module id_ex_stage #(parameter int XLEN = 32) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_ctrl;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [1:0]      result_src;
    logic            valid;
  } ex_regs_t;

  ex_regs_t        q;
  ex_regs_t        d;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  always_comb begin
    d            = '0;
    d.rd1        = bus.RD1D;
    d.rd2        = bus.RD2D;
    d.imm        = bus.ImmExtD;
    d.pc         = bus.PCD;
    d.pc_plus4   = bus.PCPlus4D;
    d.rs1        = bus.Rs1D;
    d.rs2        = bus.Rs2D;
    d.rd         = bus.RdD;
    d.alu_ctrl   = bus.ALUCtrlD;
    d.alu_src    = bus.ALUSrcD;
    d.reg_write  = bus.RegWriteD;
    d.mem_write  = bus.MemWriteD;
    d.jump       = bus.JumpD;
    d.branch     = bus.BranchD;
    d.result_src = bus.ResultSrcD;
    d.valid      = 1'b1;
  end

  // A bubble is the all-zero record, so flush wins even when stall is also set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bus.FlushE) begin
      q <= '0;
    end else if (!bus.StallE) begin
      q <= d;
    end
  end

  // Select 11 is reserved and falls back to the registered operand.
  always_comb begin
    fwd_a = q.rd1;
    case (bus.ForwardAE)
      2'b10:   fwd_a = bus.ALUResultM;
      2'b01:   fwd_a = bus.ResultW;
      default: fwd_a = q.rd1;
    endcase
  end

  always_comb begin
    fwd_b = q.rd2;
    case (bus.ForwardBE)
      2'b10:   fwd_b = bus.ALUResultM;
      2'b01:   fwd_b = bus.ResultW;
      default: fwd_b = q.rd2;
    endcase
  end

  assign bus.SrcAE      = fwd_a;
  assign bus.SrcBE      = q.alu_src ? q.imm : fwd_b;
  assign bus.WriteDataE = fwd_b;
  assign bus.PCTargetE  = q.pc + q.imm;
  assign bus.PCPlus4E   = q.pc_plus4;
  assign bus.ALUCtrlE   = q.alu_ctrl;
  assign bus.Rs1E       = q.rs1;
  assign bus.Rs2E       = q.rs2;
  assign bus.RdE        = q.rd;
  assign bus.RegWriteE  = q.reg_write;
  assign bus.MemWriteE  = q.mem_write;
  assign bus.JumpE      = q.jump;
  assign bus.BranchE    = q.branch;
  assign bus.ValidE     = q.valid;
  assign bus.ResultSrcE = q.result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a record-level model of the
// ID/EX register kept in the bench.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();
  id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic        alusrc, regw, memw, jump, branch, valid;
    logic [1:0]  ressrc;
  } rec_t;

  rec_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] mem_v, input logic [31:0] wb_v);
    if (sel == 2'd2) return mem_v;
    if (sel == 2'd1) return wb_v;
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] a, b;
    a = pick(bus.ForwardAE, m.rd1, bus.ALUResultM, bus.ResultW);
    b = pick(bus.ForwardBE, m.rd2, bus.ALUResultM, bus.ResultW);
    chk({tag, ".SrcAE"}, bus.SrcAE, a);
    chk({tag, ".SrcBE"}, bus.SrcBE, m.alusrc ? m.imm : b);
    chk({tag, ".WriteDataE"}, bus.WriteDataE, b);
    chk({tag, ".PCTargetE"}, bus.PCTargetE, 32'((64'(m.pc) + 64'(m.imm)) % 64'h1_0000_0000));
    chk({tag, ".PCPlus4E"}, bus.PCPlus4E, m.pc4);
    chk({tag, ".ALUCtrlE"}, 32'(bus.ALUCtrlE), 32'(m.alu));
    chk({tag, ".Rs1E"}, 32'(bus.Rs1E), 32'(m.rs1));
    chk({tag, ".Rs2E"}, 32'(bus.Rs2E), 32'(m.rs2));
    chk({tag, ".RdE"}, 32'(bus.RdE), 32'(m.rd));
    chk({tag, ".ctrl"}, {26'd0, bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.ResultSrcE},
        {26'd0, m.regw, m.memw, m.jump, m.branch, m.ressrc});
    chk({tag, ".ValidE"}, 32'(bus.ValidE), 32'(m.valid));
  endtask

  // Advance one edge and apply the register rules to the model, then sample 1ns later.
  task automatic edge_step();
    @(posedge clk);
    if (rst || bus.FlushE) begin
      m = '0;
    end else if (!bus.StallE) begin
      m.rd1 = bus.RD1D;   m.rd2 = bus.RD2D;   m.imm = bus.ImmExtD;
      m.pc = bus.PCD;     m.pc4 = bus.PCPlus4D;
      m.rs1 = bus.Rs1D;   m.rs2 = bus.Rs2D;   m.rd = bus.RdD;
      m.alu = bus.ALUCtrlD; m.alusrc = bus.ALUSrcD;
      m.regw = bus.RegWriteD; m.memw = bus.MemWriteD;
      m.jump = bus.JumpD; m.branch = bus.BranchD; m.ressrc = bus.ResultSrcD;
      m.valid = 1'b1;
    end
    #1;
  endtask

  task automatic rand_d();
    bus.RD1D = $urandom;  bus.RD2D = $urandom;  bus.ImmExtD = $urandom;
    bus.PCD = $urandom;   bus.PCPlus4D = $urandom;
    bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom); bus.RdD = 5'($urandom);
    bus.ALUCtrlD = 3'($urandom_range(0, 5));
    bus.ALUSrcD = 1'($urandom); bus.RegWriteD = 1'($urandom); bus.MemWriteD = 1'($urandom);
    bus.JumpD = 1'($urandom); bus.BranchD = 1'($urandom); bus.ResultSrcD = 2'($urandom);
  endtask

  task automatic rand_mw();
    bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
    bus.ALUResultM = $urandom;    bus.ResultW = $urandom;
  endtask

  initial begin
    m = '0;
    rst = 1'b1;
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
    rand_d();
    bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd0; bus.ALUResultM = '0; bus.ResultW = '0;
    edge_step();
    edge_step();
    check_all("reset");
    chk("reset.ALUCtrl_add", 32'(bus.ALUCtrlE), 32'd0);

    // Nonzero select during reset passes the forwarded value straight through.
    bus.ForwardAE = 2'b10; bus.ALUResultM = 32'hAA;
    #1;
    chk("reset.fwdA", bus.SrcAE, 32'hAA);
    check_all("reset_fwd");
    bus.ForwardAE = 2'b00;
    rst = 1'b0;

    // Normal load
    bus.RD1D = 32'd5; bus.RD2D = 32'd7; bus.ALUCtrlD = 3'b001; bus.ALUSrcD = 1'b0;
    edge_step();
    check_all("load");
    chk("load.SrcAE", bus.SrcAE, 32'd5);
    chk("load.SrcBE", bus.SrcBE, 32'd7);
    chk("load.ALUCtrlE", 32'(bus.ALUCtrlE), 32'd1);
    chk("load.ValidE", 32'(bus.ValidE), 32'd1);

    // Immediate operand and wrapping target
    bus.ALUSrcD = 1'b1; bus.ImmExtD = 32'hFFFF_FFFC; bus.PCD = 32'h0; bus.RD2D = 32'd9;
    edge_step();
    chk("imm.SrcBE", bus.SrcBE, 32'hFFFF_FFFC);
    chk("imm.WriteDataE", bus.WriteDataE, 32'd9);
    chk("imm.PCTargetE", bus.PCTargetE, 32'hFFFF_FFFC);
    bus.PCD = 32'h10; bus.ImmExtD = 32'hFFFF_FFF0;
    edge_step();
    chk("wrap.PCTargetE", bus.PCTargetE, 32'h0);

    // Forwarding
    bus.RD1D = 32'd1; bus.RD2D = 32'd2; bus.ALUSrcD = 1'b0;
    edge_step();
    bus.ALUResultM = 32'h10; bus.ResultW = 32'h20; bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01;
    #1;
    chk("fwd.SrcAE", bus.SrcAE, 32'h10);
    chk("fwd.SrcBE", bus.SrcBE, 32'h20);
    chk("fwd.WriteDataE", bus.WriteDataE, 32'h20);
    bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b10;
    #1;
    chk("fwd11.SrcAE", bus.SrcAE, 32'd1);
    chk("fwd10.SrcBE", bus.SrcBE, 32'h10);
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;

    // Stall then flush+stall
    bus.RegWriteD = 1'b1; bus.RdD = 5'd3;
    edge_step();
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      edge_step();
      chk("stall.RdE", 32'(bus.RdE), 32'd3);
      chk("stall.RegWriteE", 32'(bus.RegWriteE), 32'd1);
      check_all("stall");
    end
    bus.FlushE = 1'b1;
    edge_step();
    chk("flush.RegWriteE", 32'(bus.RegWriteE), 32'd0);
    chk("flush.RdE", 32'(bus.RdE), 32'd0);
    chk("flush.ValidE", 32'(bus.ValidE), 32'd0);
    bus.FlushE = 1'b0;
    rand_d();
    edge_step();
    chk("held_bubble.ValidE", 32'(bus.ValidE), 32'd0);
    check_all("held_bubble");
    bus.StallE = 1'b0;

    // Back-to-back loads
    for (int i = 1; i <= 3; i++) begin
      rand_d();
      bus.RdD = 5'(i);
      edge_step();
      chk("b2b.RdE", 32'(bus.RdE), 32'(i));
    end

    // Asynchronous reset between edges
    rand_d();
    edge_step();
    #2 rst = 1'b1;
    m = '0;
    #1;
    chk("async_rst.ValidE", 32'(bus.ValidE), 32'd0);
    check_all("async_rst");
    rst = 1'b0;
    edge_step();
    check_all("post_rst_load");

    // Randomized operation
    for (int i = 0; i < 300; i++) begin
      rand_d();
      rand_mw();
      bus.StallE = ($urandom_range(0, 3) == 0);
      bus.FlushE = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        m = '0;
        #1;
        check_all("rand_rst");
        rst = 1'b0;
      end
      edge_step();
      check_all("rand");
      rand_mw();
      #1;
      check_all("rand_mw");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
